muldiv_sequencer: RTL

// - Multi-cycle controller for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the single-cycle ALU.
// - Accepts one op on start, iterates a radix-2 shift-add multiply / restoring divide, then applies sign correction.
// - Raises busy to stall the execute stage and pulses done with a registered result for writeback.

---
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : muldiv_sequencer                                               |
// | Purpose : Multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/   |
// |           REM/REMU). Radix-2 shift-add multiply and restoring divide on  |
// |           operand magnitudes, followed by a sign-correction step.        |
// | Ports   : clk, rst_n (sync, active low)                                  |
// |           start, funct3[2:0], src_a/src_b[XLEN-1:0], kill   (inputs)     |
// |           busy, done, result[XLEN-1:0]                      (outputs)    |
// | Config  : MULDIV_EARLY_EXIT_EN - divide-by-zero and zero-operand         |
// |           multiplies finish straight from IDLE (done one cycle later).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int c_cnt_w = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_cnt_one = {{(c_cnt_w-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;       // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------- operand decode at accept ----------------
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sa       = w_a_signed && src_a[XLEN-1];
  assign w_sb       = w_b_signed && src_b[XLEN-1];
  assign w_mag_a    = w_sa ? -src_a : src_a;
  assign w_mag_b    = w_sb ? -src_b : src_b;

  logic            w_early;
  logic [XLEN-1:0] w_early_res;
`ifdef MULDIV_EARLY_EXIT_EN
  assign w_early = funct3[2] ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`else
  assign w_early = 1'b0;
`endif
  assign w_early_res = funct3[2] ? (funct3[1] ? src_a : {XLEN{1'b1}}) : {XLEN{1'b0}};

  // ---------------- one iteration ----------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_div_tmp;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_diff;
  logic [2*XLEN-1:0] w_div_step;

  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign w_mul_step = {w_mul_sum, acc_q[XLEN-1:1]};

  // Remainder is always below the divisor, so the shifted value fits XLEN+1
  // bits and a successful trial difference fits back into XLEN bits.
  assign w_div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_div_ge   = (w_div_tmp >= {1'b0, opnd_q});
  assign w_div_diff = w_div_tmp[XLEN-1:0] - opnd_q;
  assign w_div_step = {(w_div_ge ? w_div_diff : w_div_tmp[XLEN-1:0]), acc_q[XLEN-2:0], w_div_ge};

  // ---------------- sign correction ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix, w_fix_res;
  logic              w_div0;

  assign w_prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign w_quo     = acc_q[XLEN-1:0];
  assign w_rem     = acc_q[2*XLEN-1:XLEN];
  assign w_div0    = (opnd_q == '0);
  // A zero divisor yields an all-ones quotient and the dividend magnitude as
  // remainder; keeping the quotient unsigned and re-applying the dividend sign
  // to the remainder gives all ones / src_a without a dedicated path.
  assign w_quo_fix = ((sign_a_q ^ sign_b_q) && !w_div0) ? -w_quo : w_quo;
  assign w_rem_fix = sign_a_q ? -w_rem : w_rem;
  assign w_fix_res = op_q[2] ? (op_q[1] ? w_rem_fix : w_quo_fix)
                             : ((op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d     = funct3;
          sign_a_d = w_sa;
          sign_b_d = w_sb;
          cnt_d    = c_cnt_w'(XLEN - 1);
          if (funct3[2]) begin
            opnd_d = w_mag_b;
            acc_d  = {{XLEN{1'b0}}, w_mag_a};
          end else begin
            opnd_d = w_mag_a;
            acc_d  = {{XLEN{1'b0}}, w_mag_b};
          end
          state_d = S_CALC;
          if (w_early) begin
            result_d = w_early_res;
            state_d  = S_DONE;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? w_div_step : w_mul_step;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - c_cnt_one;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = w_fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !kill;
  assign result = result_q;

endmodule
`default_nettype wire
